// File: rtl/tx_frame_sequencer.sv
// Per-request word scheduler for the ASK modulator: idle fill, preamble, sync, payload, gap.
// Answers each mod_new_word one cycle later via mod_word/mod_load; s_ready only on PAY requests, underruns filled.
module tx_frame_sequencer #(
   parameter int                WORD_W        = 16,
   parameter int                PRE_LEN       = 4,
   parameter int                FRAME_LEN     = 64,
   parameter int                GAP_LEN       = 2,
   parameter logic [WORD_W-1:0] PREAMBLE_WORD = 16'hAAAA,
   parameter logic [WORD_W-1:0] SYNC_WORD     = 16'hD391,
   parameter logic [WORD_W-1:0] IDLE_WORD     = 16'h0000,
   parameter logic [WORD_W-1:0] FILL_WORD     = 16'h5555,
   parameter int                CNT_W         = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              mod_new_word,
   output logic [WORD_W-1:0] mod_word,
   output logic              mod_load,
   output logic              busy,
   output logic              frame_done,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic [CNT_W-1:0]  underrun_cnt
);

   localparam int MAX_A   = (PRE_LEN > FRAME_LEN) ? PRE_LEN : FRAME_LEN;
   localparam int MAX_LEN = (MAX_A > GAP_LEN) ? MAX_A : GAP_LEN;
   localparam int IDX_W   = $clog2(MAX_LEN + 1);

   localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(PRE_LEN - 1);
   localparam logic [IDX_W-1:0] PAY_LAST = IDX_W'(FRAME_LEN - 1);
   localparam logic [IDX_W-1:0] GAP_LAST = IDX_W'(GAP_LEN - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_SYNC,
      ST_PAY,
      ST_GAP
   } state_t;

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt;
   logic [WORD_W-1:0] word_nxt;
   logic              underrun_inc;
   logic              done_nxt;

   assign s_ready = (state == ST_PAY) && mod_new_word;

   always_comb begin
      state_nxt    = state;
      idx_nxt      = idx;
      word_nxt     = mod_word;
      underrun_inc = 1'b0;
      done_nxt     = 1'b0;
      if (mod_new_word) begin
         case (state)
            ST_IDLE: begin
               if (enable && s_valid) begin
                  word_nxt = PREAMBLE_WORD;
                  if (PRE_LEN == 1) begin
                     state_nxt = ST_SYNC;
                     idx_nxt   = '0;
                  end else begin
                     state_nxt = ST_PRE;
                     idx_nxt   = IDX_W'(1);
                  end
               end else begin
                  word_nxt = IDLE_WORD;
               end
            end
            ST_PRE: begin
               word_nxt = PREAMBLE_WORD;
               if (idx == PRE_LAST) begin
                  state_nxt = ST_SYNC;
                  idx_nxt   = '0;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
            ST_SYNC: begin
               word_nxt  = SYNC_WORD;
               state_nxt = ST_PAY;
               idx_nxt   = '0;
            end
            ST_PAY: begin
               // A missing payload word is replaced, never waited for: the modulator cannot stall.
               if (s_valid) begin
                  word_nxt = s_data;
               end else begin
                  word_nxt     = FILL_WORD;
                  underrun_inc = 1'b1;
               end
               if (idx == PAY_LAST) begin
                  state_nxt = ST_GAP;
                  idx_nxt   = '0;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
            ST_GAP: begin
               word_nxt = IDLE_WORD;
               if (idx == GAP_LAST) begin
                  state_nxt = ST_IDLE;
                  idx_nxt   = '0;
                  done_nxt  = 1'b1;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               idx_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         idx          <= '0;
         mod_word     <= IDLE_WORD;
         mod_load     <= 1'b0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
         frame_cnt    <= '0;
         underrun_cnt <= '0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         mod_word   <= word_nxt;
         mod_load   <= mod_new_word;
         busy       <= (state_nxt != ST_IDLE);
         frame_done <= done_nxt;
         if (done_nxt) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
         end
         if (underrun_inc && (underrun_cnt != {CNT_W{1'b1}})) begin
            underrun_cnt <= underrun_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Bench for tx_frame_sequencer: random request spacing and idle-cycle inputs, checked against a
// frame-position model plus explicit expected word sequences per scenario.
module tb_tx_frame_sequencer;

   localparam int          PRE   = 4;
   localparam int          PAY   = 64;
   localparam int          GAP   = 2;
   localparam int          TOTAL = PRE + 1 + PAY + GAP;
   localparam logic [15:0] W_PRE  = 16'hAAAA;
   localparam logic [15:0] W_SYNC = 16'hD391;
   localparam logic [15:0] W_IDLE = 16'h0000;
   localparam logic [15:0] W_FILL = 16'h5555;

   typedef logic [15:0] wq_t[$];

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        mod_new_word = 1'b0;
   logic [15:0] mod_word;
   logic        mod_load;
   logic        busy;
   logic        frame_done;
   logic [15:0] frame_cnt;
   logic [15:0] underrun_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: position within the frame on the wire (-1 = idle), plus counters.
   int          m_pos    = -1;
   logic [15:0] m_word   = 16'h0000;
   int          m_frames = 0;
   int          m_under  = 0;
   bit          m_done;
   bit          m_took;
   int          next_data;
   wq_t         cap_q;

   tx_frame_sequencer #(
      .WORD_W(16), .PRE_LEN(PRE), .FRAME_LEN(PAY), .GAP_LEN(GAP),
      .PREAMBLE_WORD(W_PRE), .SYNC_WORD(W_SYNC), .IDLE_WORD(W_IDLE),
      .FILL_WORD(W_FILL), .CNT_W(16)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .mod_new_word(mod_new_word), .mod_word(mod_word),
      .mod_load(mod_load), .busy(busy), .frame_done(frame_done),
      .frame_cnt(frame_cnt), .underrun_cnt(underrun_cnt)
   );

   always #5 clk = ~clk;

   function automatic wq_t build_expected(input int hole_lo, input int hole_hi);
      wq_t q;
      int  d = 1;
      for (int i = 0; i < PRE; i++) q.push_back(W_PRE);
      q.push_back(W_SYNC);
      for (int p = 1; p <= PAY; p++) begin
         if (p >= hole_lo && p <= hole_hi) q.push_back(W_FILL);
         else begin
            q.push_back(16'(d));
            d++;
         end
      end
      for (int i = 0; i < GAP; i++) q.push_back(W_IDLE);
      return q;
   endfunction

   // One clock cycle: drive inputs, check s_ready mid-cycle, advance model, check outputs after the edge.
   task automatic step(input bit r, input bit req, input bit en, input bit vld, input logic [15:0] dat);
      bit in_pay;
      bit exp_rdy;
      rst = r; mod_new_word = req; enable = en; s_valid = vld; s_data = dat;
      @(negedge clk);
      in_pay  = (m_pos >= PRE + 1) && (m_pos < PRE + 1 + PAY);
      exp_rdy = req && in_pay;
      if (!r) begin
         n_tests++;
         if (s_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL s_ready: got %b expected %b (pos %0d)", s_ready, exp_rdy, m_pos);
         end
      end
      m_done = 1'b0;
      m_took = 1'b0;
      if (r) begin
         m_pos = -1; m_word = W_IDLE; m_frames = 0; m_under = 0;
      end else if (req) begin
         if (m_pos < 0 && en && vld) m_pos = 0;
         if (m_pos < 0) m_word = W_IDLE;
         else begin
            if (m_pos < PRE) m_word = W_PRE;
            else if (m_pos == PRE) m_word = W_SYNC;
            else if (in_pay) begin
               if (vld) begin
                  m_word = dat;
                  m_took = 1'b1;
               end else begin
                  m_word = W_FILL;
                  if (m_under < 65535) m_under++;
               end
            end else m_word = W_IDLE;
            m_pos++;
            if (m_pos == TOTAL) begin
               m_pos = -1;
               m_done = 1'b1;
               m_frames = (m_frames + 1) % 65536;
            end
         end
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (mod_load !== (req && !r)) begin
         n_fail++;
         $display("FAIL mod_load: got %b expected %b", mod_load, req && !r);
      end
      n_tests++;
      if (mod_word !== m_word) begin
         n_fail++;
         $display("FAIL mod_word: got %h expected %h", mod_word, m_word);
      end
      n_tests++;
      if (frame_done !== m_done) begin
         n_fail++;
         $display("FAIL frame_done: got %b expected %b", frame_done, m_done);
      end
      n_tests++;
      if (busy !== (m_pos >= 0)) begin
         n_fail++;
         $display("FAIL busy: got %b expected %b", busy, m_pos >= 0);
      end
      n_tests++;
      if (frame_cnt !== 16'(m_frames) || underrun_cnt !== 16'(m_under)) begin
         n_fail++;
         $display("FAIL counters: got frame %0d underrun %0d expected %0d %0d",
                  frame_cnt, underrun_cnt, m_frames, m_under);
      end
      if (mod_load === 1'b1) cap_q.push_back(mod_word);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 16'($urandom));
   endtask

   // Drives one frame from IDLE; hole = payload requests with s_valid low, drop_at/rst_at = payload index.
   task automatic run_frame(input int gap_max, input int hole_lo, input int hole_hi,
                            input int drop_at, input int rst_at, output bit ok);
      int pidx;
      bit en, vld, r;
      cap_q.delete();
      next_data = 1;
      ok = 1'b0;
      for (int b = 0; b < 3000 && !ok; b++) begin
         pidx = (m_pos >= PRE + 1 && m_pos < PRE + 1 + PAY) ? m_pos - PRE : 0;
         vld  = !(pidx != 0 && pidx >= hole_lo && pidx <= hole_hi);
         en   = !(drop_at > 0 && m_pos >= PRE + drop_at);
         r    = (rst_at > 0 && pidx == rst_at);
         step(r, 1'b1, en, vld, 16'(next_data));
         if (m_took) next_data++;
         if (r || m_done) ok = 1'b1;
         else idle_cycles(int'($urandom_range(0, gap_max)));
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL frame_timeout: got no completion expected frame within 3000 requests");
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'b1, 1'b1, 16'($urandom));
      n_tests++;
      if (mod_word !== W_IDLE || mod_load !== 1'b0 || frame_done !== 1'b0 ||
          frame_cnt !== 16'd0 || underrun_cnt !== 16'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got word %h load %b done %b fc %0d uc %0d busy %b expected 0000 0 0 0 0 0",
                  mod_word, mod_load, frame_done, frame_cnt, underrun_cnt, busy);
      end
   endtask

   task automatic test_idle_disabled();
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b1, 1'b0, 1'($urandom), 16'($urandom));
         n_tests++;
         if (mod_word !== W_IDLE || mod_load !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_word: got %h load %b busy %b expected 0000 1 0", mod_word, mod_load, busy);
         end
         idle_cycles(7);
      end
   endtask

   task automatic test_frame();
      bit  ok;
      wq_t exp;
      int  bad;
      run_frame(3, 0, 0, 0, 0, ok);
      exp = build_expected(0, 0);
      bad = -1;
      for (int i = 0; i < exp.size() && i < cap_q.size(); i++)
         if (bad < 0 && cap_q[i] !== exp[i]) bad = i;
      n_tests++;
      if (cap_q.size() != TOTAL || bad >= 0) begin
         n_fail++;
         $display("FAIL frame_seq: got %0d words (first bad idx %0d) expected %0d words", cap_q.size(), bad, TOTAL);
      end
      n_tests++;
      if (frame_cnt !== 16'd1 || underrun_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL frame_counts: got fc %0d uc %0d expected 1 0", frame_cnt, underrun_cnt);
      end
   endtask

   task automatic test_underrun();
      bit  ok;
      wq_t exp;
      int  bad;
      run_frame(2, 10, 12, 0, 0, ok);
      exp = build_expected(10, 12);
      bad = -1;
      for (int i = 0; i < exp.size() && i < cap_q.size(); i++)
         if (bad < 0 && cap_q[i] !== exp[i]) bad = i;
      n_tests++;
      if (cap_q.size() != TOTAL || bad >= 0) begin
         n_fail++;
         $display("FAIL underrun_seq: got %0d words (first bad idx %0d) expected %0d words", cap_q.size(), bad, TOTAL);
      end
      n_tests++;
      if (underrun_cnt !== 16'd3 || frame_cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL underrun_counts: got uc %0d fc %0d expected 3 2", underrun_cnt, frame_cnt);
      end
   endtask

   task automatic test_back_to_back();
      bit  ok;
      wq_t exp;
      int  bad;
      run_frame(0, 0, 0, 0, 0, ok);
      exp = build_expected(0, 0);
      bad = -1;
      for (int i = 0; i < exp.size() && i < cap_q.size(); i++)
         if (bad < 0 && cap_q[i] !== exp[i]) bad = i;
      n_tests++;
      if (cap_q.size() != TOTAL || bad >= 0) begin
         n_fail++;
         $display("FAIL b2b_seq: got %0d words (first bad idx %0d) expected %0d words", cap_q.size(), bad, TOTAL);
      end
   endtask

   task automatic test_mid_frame_reset();
      bit ok;
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      run_frame(1, 0, 0, 0, 20, ok);
      n_tests++;
      if (mod_word !== W_IDLE || busy !== 1'b0 || frame_cnt !== 16'd0 || frame_done !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: got word %h busy %b fc %0d done %b expected 0000 0 0 0",
                  mod_word, busy, frame_cnt, frame_done);
      end
      idle_cycles(3);
      run_frame(1, 0, 0, 0, 0, ok);
      n_tests++;
      if (cap_q.size() < PRE + 1 || cap_q[0] !== W_PRE || cap_q[3] !== W_PRE || cap_q[4] !== W_SYNC) begin
         n_fail++;
         $display("FAIL restart_preamble: got %0d words expected 4x AAAA then D391", cap_q.size());
      end
      n_tests++;
      if (frame_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL restart_count: got %0d expected 1", frame_cnt);
      end
   endtask

   task automatic test_enable_drop();
      bit ok;
      run_frame(2, 0, 0, 30, 0, ok);
      n_tests++;
      if (cap_q.size() != TOTAL || frame_cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL enable_drop_frame: got %0d words fc %0d expected %0d words fc 2", cap_q.size(), frame_cnt, TOTAL);
      end
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b1, 1'b0, 1'b1, 16'($urandom));
         n_tests++;
         if (mod_word !== W_IDLE || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_low_idle: got %h busy %b expected 0000 0", mod_word, busy);
         end
         idle_cycles(int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_idle_disabled();
      test_frame();
      test_underrun();
      test_back_to_back();
      test_mid_frame_reset();
      test_enable_drop();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
